// File: rtl/piso_tx_arbiter.sv
// Round-robin scheduler that shares one PISO serializer among NREQ requesters.
// Loads the winner's word with a one-cycle start pulse, then holds off for frame + gap.
module piso_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int FRAME_CYCLES = 40,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     data,
  output logic [NREQ-1:0]           ack,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      piso_start,
  output logic [WIDTH-1:0]          piso_din,
  output logic                      busy,
  output logic                      done
);

  localparam int IW       = $clog2(NREQ);
  localparam int CW       = $clog2(FRAME_CYCLES + 1);
  localparam int GW       = $clog2(GAP_CYCLES + 2);
  localparam int GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_INIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic              piso_start_q, piso_start_d;
  logic [WIDTH-1:0]  piso_din_q, piso_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              found;
  logic [IW-1:0]     win;
  int                idx;

  // Rotating-priority scan: first pending requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    ack_d        = '0;
    grant_id_d   = grant_id_q;
    piso_start_d = 1'b0;
    piso_din_d   = piso_din_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          piso_start_d = 1'b1;
          piso_din_d   = data[int'(win)*WIDTH +: WIDTH];
          ack_d[win]   = 1'b1;
          grant_id_d   = win;
          ptr_d        = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          cnt_d        = FRAME_LOAD;
          state_d      = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gcnt_d  = GAP_LOAD;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      GAP: begin
        if (gcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // busy is registered alongside state so it tracks state != IDLE exactly.
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      ack_q        <= '0;
      grant_id_q   <= '0;
      piso_start_q <= 1'b0;
      piso_din_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      ack_q        <= ack_d;
      grant_id_q   <= grant_id_d;
      piso_start_q <= piso_start_d;
      piso_din_q   <= piso_din_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ack        = ack_q;
  assign grant_id   = grant_id_q;
  assign piso_start = piso_start_q;
  assign piso_din   = piso_din_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter: a vector table of single loads plus
// hand-written multi-cycle sequences; a second instance runs with no guard gap.
module tb_piso_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int FRAME = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_a = '0, req_b = '0;
  logic [NREQ*W-1:0] data_a = '0, data_b = '0;
  logic [NREQ-1:0]   ack_a, ack_b;
  logic [1:0]        id_a, id_b;
  logic              start_a, start_b;
  logic [W-1:0]      din_a, din_b;
  logic              busy_a, busy_b;
  logic              done_a, done_b;

  piso_tx_arbiter #(.NREQ(NREQ), .WIDTH(W), .FRAME_CYCLES(FRAME), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .data(data_a), .ack(ack_a), .grant_id(id_a),
    .piso_start(start_a), .piso_din(din_a), .busy(busy_a), .done(done_a)
  );

  piso_tx_arbiter #(.NREQ(NREQ), .WIDTH(W), .FRAME_CYCLES(FRAME), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .data(data_b), .ack(ack_b), .grant_id(id_b),
    .piso_start(start_b), .piso_din(din_b), .busy(busy_b), .done(done_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Cycles until the next start pulse on instance A; -1 if none within bound.
  task automatic wait_start_a(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (start_a) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 200; i++) begin
      if (!busy_a) break;
      step();
    end
    check("wait_idle_a", 32'(busy_a), 32'd0);
  endtask

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic [NREQ-1:0]   exp_ack;
    logic [1:0]        exp_id;
    logic [W-1:0]      exp_din;
  } vec_t;

  vec_t vecs [8];

  int n, n_done, n_idle, done_cnt, bad, busy_at_done;

  initial begin
    // Pointer evolves across rows: 0 -> 1 -> 1 -> 0 -> 2 -> 1 -> 0 -> 3
    vecs[0] = '{4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b0001, 32'h1234_5678, 4'b0001, 2'd0, 8'h78};
    vecs[2] = '{4'b1001, 32'h9ABC_DEF0, 4'b1000, 2'd3, 8'h9A};
    vecs[3] = '{4'b0110, 32'h4433_2211, 4'b0010, 2'd1, 8'h22};
    vecs[4] = '{4'b0011, 32'h5566_7788, 4'b0001, 2'd0, 8'h88};
    vecs[5] = '{4'b1000, 32'hC0FF_EE01, 4'b1000, 2'd3, 8'hC0};
    vecs[6] = '{4'b1100, 32'hDEAD_BEEF, 4'b0100, 2'd2, 8'hAD};
    vecs[7] = '{4'b0111, 32'h0F1E_2D3C, 4'b0001, 2'd0, 8'h3C};

    // Reset state of both instances
    rst = 1'b0;
    step();
    step();
    check("rst_a_ack",   32'(ack_a),   32'd0);
    check("rst_a_id",    32'(id_a),    32'd0);
    check("rst_a_start", 32'(start_a), 32'd0);
    check("rst_a_din",   32'(din_a),   32'd0);
    check("rst_a_busy",  32'(busy_a),  32'd0);
    check("rst_a_done",  32'(done_a),  32'd0);
    check("rst_b_busy",  32'(busy_b),  32'd0);
    check("rst_b_start", 32'(start_b), 32'd0);
    rst = 1'b1;
    step();

    // Table of single loads, each followed by frame/done/idle timing
    for (int v = 0; v < 8; v++) begin
      req_a  = vecs[v].req;
      data_a = vecs[v].data;
      step();
      check($sformatf("v%0d_start", v), 32'(start_a), 32'd1);
      check($sformatf("v%0d_ack", v),   32'(ack_a),   32'(vecs[v].exp_ack));
      check($sformatf("v%0d_id", v),    32'(id_a),    32'(vecs[v].exp_id));
      check($sformatf("v%0d_din", v),   32'(din_a),   32'(vecs[v].exp_din));
      check($sformatf("v%0d_busy", v),  32'(busy_a),  32'd1);
      req_a = '0;
      n_done = -1; n_idle = -1; done_cnt = 0;
      for (int i = 1; i <= 200; i++) begin
        step();
        if (done_a) begin
          done_cnt++;
          if (n_done < 0) n_done = i;
        end
        if (!busy_a) begin
          n_idle = i;
          break;
        end
      end
      check($sformatf("v%0d_done_at", v),   32'(n_done),   32'd40);
      check($sformatf("v%0d_done_cnt", v),  32'(done_cnt), 32'd1);
      check($sformatf("v%0d_idle_at", v),   32'(n_idle),   32'd42);
    end

    // Continuous demand from all four: rotation 0,1,2,3,0 at 43-cycle spacing
    do_reset();
    req_a  = 4'b1111;
    data_a = 32'h4433_2211;
    step();
    check("rr_start0", 32'(start_a), 32'd1);
    check("rr_id0",    32'(id_a),    32'd0);
    check("rr_din0",   32'(din_a),   32'h11);
    step();
    check("rr_start_pulse", 32'(start_a), 32'd0);
    check("rr_ack_pulse",   32'(ack_a),   32'd0);
    wait_start_a(n);
    check("rr_space1", 32'(n + 1), 32'd43);
    check("rr_id1",    32'(id_a),  32'd1);
    check("rr_din1",   32'(din_a), 32'h22);
    wait_start_a(n);
    check("rr_space2", 32'(n),     32'd43);
    check("rr_id2",    32'(id_a),  32'd2);
    check("rr_din2",   32'(din_a), 32'h33);
    wait_start_a(n);
    check("rr_space3", 32'(n),     32'd43);
    check("rr_id3",    32'(id_a),  32'd3);
    check("rr_din3",   32'(din_a), 32'h44);
    wait_start_a(n);
    check("rr_space4", 32'(n),     32'd43);
    check("rr_id4",    32'(id_a),  32'd0);
    check("rr_din4",   32'(din_a), 32'h11);
    req_a = '0;

    // After grant to 1 (ptr=2), req=1010 -> 3 then 1
    do_reset();
    req_a  = 4'b0010;
    data_a = 32'hB3B2_B1B0;
    step();
    check("ptr_first_id", 32'(id_a), 32'd1);
    req_a = 4'b1010;
    wait_start_a(n);
    check("ptr_second_id",  32'(id_a),  32'd3);
    check("ptr_second_ack", 32'(ack_a), 32'b1000);
    check("ptr_second_din", 32'(din_a), 32'hB3);
    req_a = 4'b0010;
    wait_start_a(n);
    check("ptr_third_id",  32'(id_a),  32'd1);
    check("ptr_third_din", 32'(din_a), 32'hB1);
    req_a = '0;

    // Requests and data changes mid-frame are ignored until IDLE
    do_reset();
    req_a  = 4'b0001;
    data_a = 32'h0000_005A;
    step();
    check("mid_start", 32'(start_a), 32'd1);
    check("mid_din0",  32'(din_a),   32'h5A);
    req_a = '0;
    repeat (5) step();
    req_a  = 4'b0100;
    data_a = 32'h0077_00FF;
    bad = 0;
    n = -1;
    for (int i = 6; i <= 200; i++) begin
      step();
      if (start_a) begin
        n = i;
        break;
      end
      if (ack_a != '0 || din_a != 8'h5A) bad++;
    end
    check("mid_no_disturb", 32'(bad), 32'd0);
    check("mid_next_at",    32'(n),     32'd43);
    check("mid_next_id",    32'(id_a),  32'd2);
    check("mid_next_ack",   32'(ack_a), 32'b0100);
    check("mid_next_din",   32'(din_a), 32'h77);
    req_a = '0;

    // Asynchronous reset 10 cycles into WAIT
    do_reset();
    req_a  = 4'b0010;
    data_a = 32'h0000_AB00;
    step();
    check("ar_pre_id", 32'(id_a), 32'd1);
    req_a = '0;
    repeat (10) step();
    check("ar_pre_busy", 32'(busy_a), 32'd1);
    rst = 1'b0;
    #1;
    check("ar_busy",  32'(busy_a),  32'd0);
    check("ar_id",    32'(id_a),    32'd0);
    check("ar_din",   32'(din_a),   32'd0);
    check("ar_ack",   32'(ack_a),   32'd0);
    check("ar_start", 32'(start_a), 32'd0);
    check("ar_done",  32'(done_a),  32'd0);
    step();
    rst = 1'b1;
    req_a  = 4'b0110;
    data_a = 32'h00CD_EF00;
    step();
    check("ar_post_start", 32'(start_a), 32'd1);
    check("ar_post_id",    32'(id_a),    32'd1);
    check("ar_post_din",   32'(din_a),   32'hEF);
    req_a = '0;
    step();
    wait_idle_a();
    req_a = 4'b0100;
    step();
    check("ar_req2_start", 32'(start_a), 32'd1);
    check("ar_req2_id",    32'(id_a),    32'd2);
    check("ar_req2_din",   32'(din_a),   32'hCD);
    req_a = '0;

    // No guard gap: done coincides with IDLE, 41-cycle start spacing
    req_b  = 4'b0011;
    data_b = 32'h0000_2211;
    step();
    check("ng_start0", 32'(start_b), 32'd1);
    check("ng_id0",    32'(id_b),    32'd0);
    check("ng_din0",   32'(din_b),   32'h11);
    n_done = -1; n = -1; busy_at_done = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (done_b && n_done < 0) begin
        n_done       = i;
        busy_at_done = int'(busy_b);
      end
      if (start_b) begin
        n = i;
        break;
      end
    end
    check("ng_done_at",      32'(n_done),       32'd40);
    check("ng_busy_at_done", 32'(busy_at_done), 32'd0);
    check("ng_next_at",      32'(n),            32'd41);
    check("ng_id1",          32'(id_b),         32'd1);
    check("ng_din1",         32'(din_b),        32'h22);
    req_b = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
